branch_predictor: RTL

- Direct-mapped branch target buffer (BTB) with 2-bit saturating direction counters for the mips_pipeline fetch stage.
- IF presents the fetch PC and receives a same-cycle predicted next PC.
- EX writes back the resolved branch outcome and target one update per cycle.
- Keeps branch and mispredict statistics readable from benches.

---
 rtl/mips_pkg.sv | 41 ++++
 rtl/bp_sat_counter32.sv | 39 +++
 rtl/branch_predictor.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// Shared definitions for the mips_pipeline fetch-side blocks.
//
// Contents:
//   PC_W               - architectural PC width (32).
//   ctr_e              - 2-bit branch direction counter states
//                        SNT=00, WNT=01, WT=10, ST=11.
//   sat2_inc/sat2_dec  - saturating step of a direction counter.
package mips_pkg;

  localparam int PC_W = 32;

  typedef enum logic [1:0] {
    CTR_SNT = 2'b00,
    CTR_WNT = 2'b01,
    CTR_WT  = 2'b10,
    CTR_ST  = 2'b11
  } ctr_e;

  // Move one step towards strongly-taken; stays at ST.
  function automatic ctr_e sat2_inc(input ctr_e c);
    ctr_e r;
    case (c)
      CTR_SNT: r = CTR_WNT;
      CTR_WNT: r = CTR_WT;
      default: r = CTR_ST;
    endcase
    return r;
  endfunction

  // Move one step towards strongly-not-taken; stays at SNT.
  function automatic ctr_e sat2_dec(input ctr_e c);
    ctr_e r;
    case (c)
      CTR_ST:  r = CTR_WT;
      CTR_WT:  r = CTR_WNT;
      default: r = CTR_SNT;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/bp_sat_counter32.sv
// Saturating 32-bit event counter used for predictor statistics.
//
// Ports:
//   clk    - system clock.
//   rst    - synchronous active-low reset; clears the count.
//   inc    - count one event at the next rising edge.
//   count  - current count; holds at 0xFFFFFFFF instead of wrapping.
module bp_sat_counter32 (
  input  logic        clk,
  input  logic        rst,
  input  logic        inc,
  output logic [31:0] count
);

  logic [31:0] count_q;
  logic [31:0] count_d;

  // NOTE: every combinational output gets a default before any branch, so
  // no path leaves it unassigned and no latch is inferred.
  always_comb begin
    count_d = count_q;
    if (inc && (count_q != 32'hFFFF_FFFF)) begin
      count_d = count_q + 32'd1;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (!rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped branch target buffer with 2-bit direction counters.
//
// IF side: if_pc is looked up combinationally; pred_taken / pred_next_pc are
// valid in the same cycle and reflect the table as it stood before any
// update applied at the coming clock edge.
// EX side: one resolved conditional branch per cycle via upd_* (ignored when
// upd_valid=0). stat_branches / stat_mispredicts count resolved branches and
// EX-detected mispredicts, saturating at 0xFFFFFFFF.
//
// Ports:
//   clk, rst          - clock, synchronous active-low reset.
//   if_pc             - fetch PC.
//   pred_taken        - 1 = predicted taken.
//   pred_next_pc      - predicted next fetch PC.
//   upd_valid         - resolved branch present this cycle.
//   upd_pc            - PC of the resolved branch.
//   upd_taken         - actual direction.
//   upd_target        - actual taken target.
//   upd_mispredict    - EX saw a wrong next PC (statistics only).
//   stat_branches     - resolved branch count.
//   stat_mispredicts  - mispredict count.
module branch_predictor
  import mips_pkg::*;
#(
  parameter int INDEX_BITS = 6,
  parameter int TAG_BITS   = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [PC_W-1:0] if_pc,
  output logic            pred_taken,
  output logic [PC_W-1:0] pred_next_pc,
  input  logic            upd_valid,
  input  logic [PC_W-1:0] upd_pc,
  input  logic            upd_taken,
  input  logic [PC_W-1:0] upd_target,
  input  logic            upd_mispredict,
  output logic [31:0]     stat_branches,
  output logic [31:0]     stat_mispredicts
);

  localparam int ENTRIES = 1 << INDEX_BITS;
  localparam int TAG_LO  = INDEX_BITS + 2;
  localparam int TAG_HI  = INDEX_BITS + TAG_BITS + 1;

  // Table state: flat per-field register arrays.
  logic [ENTRIES-1:0]  valid_q, valid_d;
  logic [TAG_BITS-1:0] tag_q    [ENTRIES];
  logic [TAG_BITS-1:0] tag_d    [ENTRIES];
  logic [PC_W-1:0]     target_q [ENTRIES];
  logic [PC_W-1:0]     target_d [ENTRIES];
  ctr_e                ctr_q    [ENTRIES];
  ctr_e                ctr_d    [ENTRIES];

  // ---------------------------------------------------------------- lookup
  logic [INDEX_BITS-1:0] lk_idx;
  logic [TAG_BITS-1:0]   lk_tag;
  logic                  lk_hit;
  logic [1:0]            lk_ctr;

  assign lk_idx = if_pc[INDEX_BITS+1:2];
  assign lk_tag = if_pc[TAG_HI:TAG_LO];
  assign lk_hit = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
  assign lk_ctr = ctr_q[lk_idx];

  // Only the upper counter bit decides direction (WT/ST = taken).
  assign pred_taken   = lk_hit && lk_ctr[1];
  assign pred_next_pc = pred_taken ? target_q[lk_idx] : (if_pc + 32'd4);

  // ---------------------------------------------------------------- update
  logic [INDEX_BITS-1:0] up_idx;
  logic [TAG_BITS-1:0]   up_tag;
  logic                  up_hit;

  assign up_idx = upd_pc[INDEX_BITS+1:2];
  assign up_tag = upd_pc[TAG_HI:TAG_LO];
  assign up_hit = valid_q[up_idx] && (tag_q[up_idx] == up_tag);

  always_comb begin
    valid_d  = valid_q;
    tag_d    = tag_q;
    target_d = target_q;
    ctr_d    = ctr_q;
    if (upd_valid) begin
      if (up_hit) begin
        if (upd_taken) begin
          ctr_d[up_idx]    = sat2_inc(ctr_q[up_idx]);
          target_d[up_idx] = upd_target;
        end else begin
          ctr_d[up_idx] = sat2_dec(ctr_q[up_idx]);
        end
      end else if (upd_taken) begin
        // Taken miss replaces whatever occupied the slot.
        valid_d[up_idx]  = 1'b1;
        tag_d[up_idx]    = up_tag;
        target_d[up_idx] = upd_target;
        ctr_d[up_idx]    = CTR_WT;
      end
      // Not-taken miss: nothing worth remembering.
    end
  end

  // NOTE: the whole table is reset, not just the valid bits, because the
  // counters must restart at WNT and a reset-clean image is required.
  always_ff @(posedge clk) begin
    if (!rst) begin
      valid_q <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        ctr_q[i]    <= CTR_WNT;
      end
    end else begin
      valid_q  <= valid_d;
      tag_q    <= tag_d;
      target_q <= target_d;
      ctr_q    <= ctr_d;
    end
  end

  // ------------------------------------------------------------ statistics
  bp_sat_counter32 u_stat_branches (
    .clk   (clk),
    .rst   (rst),
    .inc   (upd_valid),
    .count (stat_branches)
  );

  bp_sat_counter32 u_stat_mispredicts (
    .clk   (clk),
    .rst   (rst),
    .inc   (upd_valid && upd_mispredict),
    .count (stat_mispredicts)
  );

  // Offset and high PC bits play no part in indexing or tagging.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{upd_pc[1:0], upd_pc[PC_W-1:TAG_HI+1]};

endmodule
